// File: rtl/psram_cpu_bridge_if.sv
// Bus interfaces used by psram_cpu_bridge.
//
// cpu_bus_if  : CPU request/response channel.
//   master = CPU data bus decoder, slave = bridge.
//   cpu_req_valid/ready handshake; cpu_req_we, cpu_req_addr[23:0],
//   cpu_req_wdata[31:0], cpu_req_mask[3:0]; response is a one-cycle
//   cpu_rsp_valid pulse with cpu_rsp_rdata[31:0].
//
// word_bus_if : 32-bit PSRAM word-controller channel.
//   master = bridge, slave = word controller.
//   word_rd/word_wr one-cycle command pulses with word_addr[21:0] and
//   word_data[31:0]; the controller answers with word_busy, word_q[31:0]
//   and a word_q_valid pulse.

interface cpu_bus_if;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [23:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic [3:0]  cpu_req_mask;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_mask,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata
  );

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_mask,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata
  );
endinterface

interface word_bus_if;
  logic        word_rd;
  logic        word_wr;
  logic [21:0] word_addr;
  logic [31:0] word_data;
  logic [31:0] word_q;
  logic        word_busy;
  logic        word_q_valid;

  modport master (
    output word_rd, word_wr, word_addr, word_data,
    input  word_q, word_busy, word_q_valid
  );

  modport slave (
    input  word_rd, word_wr, word_addr, word_data,
    output word_q, word_busy, word_q_valid
  );
endinterface

// File: rtl/psram_cpu_bridge.sv
// psram_cpu_bridge
// CPU-side initiator for the 32-bit PSRAM word controller. Accepts one CPU
// request at a time, issues whole-word reads/writes, and turns partial-mask
// writes into read-modify-write sequences. Mask-0 writes complete without
// touching the PSRAM. A missing busy acknowledge sets a sticky error flag.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   cpu      : cpu_bus_if.slave  (request/response channel)
//   word     : word_bus_if.master (PSRAM word-controller channel)
//   err      : sticky ack-timeout flag, cleared only by reset
//
// All outputs are registered; their next values are derived from next_state
// so that each output lines up with the state it belongs to.

module psram_cpu_bridge #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  cpu_bus_if.slave   cpu,
  word_bus_if.master word,
  output logic       err
);

  localparam logic [7:0]  ACK_LIMIT = 8'(ACK_TIMEOUT);
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, MERGE, RESP} state_t;

  state_t      state, next_state;
  logic        lat_we, lat_we_d;
  logic [31:0] lat_wdata, lat_wdata_d;
  logic [3:0]  lat_mask, lat_mask_d;
  logic        rmw, rmw_d;
  logic        issue_wr, issue_wr_d;
  logic [7:0]  ack_cnt, ack_cnt_d;
  logic [31:0] rbuf, rbuf_d;
  logic [31:0] merged;
  logic        accept, ack_timeout;
  logic        ready_d, rsp_valid_d, rd_d, wr_d, err_d;
  logic [31:0] rdata_d, data_d;
  logic [21:0] addr_d;
  logic        unused_addr_bits;

  assign accept           = cpu.cpu_req_valid & cpu.cpu_req_ready;
  assign ack_timeout      = (state == WAIT_ACK) && !word.word_busy && (ack_cnt >= ACK_LIMIT);
  assign unused_addr_bits = ^cpu.cpu_req_addr[1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept)
                   next_state = (cpu.cpu_req_we && cpu.cpu_req_mask == 4'h0) ? RESP : ISSUE;
      ISSUE:     if (!word.word_busy) next_state = WAIT_ACK;
      WAIT_ACK:  if (word.word_busy)            next_state = WAIT_DONE;
                 else if (ack_cnt >= ACK_LIMIT) next_state = RESP;
      WAIT_DONE: if (!word.word_busy) next_state = rmw ? MERGE : RESP;
      MERGE:     next_state = ISSUE;
      RESP:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output / datapath next values. The command pulse is launched on the
  // ISSUE->WAIT_ACK transition, so it lasts exactly one cycle.
  always_comb begin
    ready_d     = (next_state == IDLE);
    rsp_valid_d = (next_state == RESP);
    rd_d        = (state == ISSUE) && (next_state == WAIT_ACK) && !issue_wr;
    wr_d        = (state == ISSUE) && (next_state == WAIT_ACK) && issue_wr;
    err_d       = err | ack_timeout;

    rbuf_d = rbuf;
    if (state == WAIT_DONE && word.word_q_valid) rbuf_d = word.word_q;

    merged = rbuf;
    for (int i = 0; i < 4; i++)
      if (lat_mask[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];

    // Read data only changes for plain reads or on a timeout
    rdata_d = cpu.cpu_rsp_rdata;
    if (ack_timeout)
      rdata_d = ERR_DATA;
    else if (state == WAIT_DONE && next_state == RESP && !lat_we)
      rdata_d = rbuf_d;

    // Ack counter saturates rather than wrapping
    ack_cnt_d = ack_cnt;
    if (state == ISSUE)
      ack_cnt_d = 8'd0;
    else if (state == WAIT_ACK && ack_cnt != 8'hFF)
      ack_cnt_d = ack_cnt + 8'd1;

    addr_d      = word.word_addr;
    data_d      = word.word_data;
    lat_we_d    = lat_we;
    lat_wdata_d = lat_wdata;
    lat_mask_d  = lat_mask;
    rmw_d       = rmw;
    issue_wr_d  = issue_wr;

    if (accept) begin
      lat_we_d    = cpu.cpu_req_we;
      lat_wdata_d = cpu.cpu_req_wdata;
      lat_mask_d  = cpu.cpu_req_mask;
      issue_wr_d  = cpu.cpu_req_we && (cpu.cpu_req_mask == 4'hF);
      rmw_d       = cpu.cpu_req_we && (cpu.cpu_req_mask != 4'hF) && (cpu.cpu_req_mask != 4'h0);
      // Mask-0 writes never reach the PSRAM, so the bus keeps its old values
      if (next_state == ISSUE) begin
        addr_d = cpu.cpu_req_addr[23:2];
        if (cpu.cpu_req_we && cpu.cpu_req_mask == 4'hF) data_d = cpu.cpu_req_wdata;
      end
    end

    // Second RMW phase: merged word goes out as a full write
    if (state == MERGE) begin
      data_d     = merged;
      rmw_d      = 1'b0;
      issue_wr_d = 1'b1;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu.cpu_req_ready <= 1'b0;
      cpu.cpu_rsp_valid <= 1'b0;
      cpu.cpu_rsp_rdata <= 32'h0;
      err               <= 1'b0;
      word.word_rd      <= 1'b0;
      word.word_wr      <= 1'b0;
      word.word_addr    <= 22'h0;
      word.word_data    <= 32'h0;
      lat_we            <= 1'b0;
      lat_wdata         <= 32'h0;
      lat_mask          <= 4'h0;
      rmw               <= 1'b0;
      issue_wr          <= 1'b0;
      ack_cnt           <= 8'h0;
      rbuf              <= 32'h0;
    end else begin
      cpu.cpu_req_ready <= ready_d;
      cpu.cpu_rsp_valid <= rsp_valid_d;
      cpu.cpu_rsp_rdata <= rdata_d;
      err               <= err_d;
      word.word_rd      <= rd_d;
      word.word_wr      <= wr_d;
      word.word_addr    <= addr_d;
      word.word_data    <= data_d;
      lat_we            <= lat_we_d;
      lat_wdata         <= lat_wdata_d;
      lat_mask          <= lat_mask_d;
      rmw               <= rmw_d;
      issue_wr          <= issue_wr_d;
      ack_cnt           <= ack_cnt_d;
      rbuf              <= rbuf_d;
    end
  end

endmodule
